// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM states, access size codes and lane mask helper for the memory port arbiter
package mem_arb_pkg;
   localparam int DATA_W = 32;
   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;
   typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} state_t;
   function automatic logic [DATA_W-1:0] lane_mask(input logic [1:0] size);
      return size == SZ_BYTE ? 32'h0000_00ff : size == SZ_HALF ? 32'h0000_ffff : 32'hffff_ffff;
   endfunction
endpackage

// File: rtl/mem_arb_rr2.sv
// mem_arb_rr2: two-way round-robin picker, last_grant resets to 1 so requester 0 wins first
module mem_arb_rr2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       adv,
   output logic [1:0] gnt
);
   logic last;
   always_ff @(posedge clk)
      if (!rst_n) last <= 1'b1;
      else if (adv) last <= gnt[1];
   always_comb gnt = &req ? (last ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin share of a single-port memory with load capture, word store and byte/half read-modify-write
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int BYTE_SIZE  = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    m0_req,
   input  logic                    m0_we,
   input  logic [1:0]              m0_size,
   input  logic [ADDR_WIDTH-1:0]   m0_addr,
   input  logic [BYTE_SIZE*8-1:0]  m0_wdata,
   output logic                    m0_gnt,
   output logic                    m0_rvalid,
   output logic [BYTE_SIZE*8-1:0]  m0_rdata,
   input  logic                    m1_req,
   input  logic                    m1_we,
   input  logic [1:0]              m1_size,
   input  logic [ADDR_WIDTH-1:0]   m1_addr,
   input  logic [BYTE_SIZE*8-1:0]  m1_wdata,
   output logic                    m1_gnt,
   output logic                    m1_rvalid,
   output logic [BYTE_SIZE*8-1:0]  m1_rdata,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic                    mem_we,
   output logic [BYTE_SIZE*8-1:0]  mem_wd,
   input  logic [BYTE_SIZE*8-1:0]  mem_rd
);
   state_t state, nxt;
   logic [1:0] pick, gnt, rv_q;
   logic id_q, we_q;
   logic [1:0] size_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q, old_q, rdata_q, mask;
   assign mask = lane_mask(size_q);
   mem_arb_rr2 u_rr (.clk(clk), .rst_n(rst_n), .req({m1_req, m0_req}), .adv(|gnt), .gnt(pick));
   assign gnt = pick & {2{state == IDLE && rst_n}};
   assign m0_gnt = gnt[0];
   assign m1_gnt = gnt[1];
   assign m0_rvalid = rv_q[0];
   assign m1_rvalid = rv_q[1];
   assign m0_rdata = rdata_q;
   assign m1_rdata = rdata_q;
   always_ff @(posedge clk)
      if (!rst_n) state <= IDLE;
      else state <= nxt;
   always_comb begin
      nxt = state;
      mem_addr = '0;
      mem_we = 1'b0;
      mem_wd = '0;
      case (state)
         IDLE: nxt = |gnt ? ACCESS : IDLE;
         ACCESS: begin
            mem_addr = addr_q;
            mem_we = we_q & size_q[1];
            mem_wd = mem_we ? wdata_q : '0;
            nxt = (we_q & ~size_q[1]) ? MERGE : RESP;
         end
         MERGE: begin
            mem_addr = addr_q;
            mem_we = 1'b1;
            mem_wd = (old_q & ~mask) | (wdata_q & mask);
            nxt = RESP;
         end
         default: nxt = IDLE;
      endcase
      mem_we = mem_we & rst_n;
   end
   // size codes 2 and 3 both have bit 1 set, so size_q[1] alone means "full word"
   always_ff @(posedge clk)
      if (!rst_n) begin
         id_q <= 1'b0;
         we_q <= 1'b0;
         size_q <= SZ_BYTE;
         addr_q <= '0;
         wdata_q <= '0;
         old_q <= '0;
         rdata_q <= '0;
         rv_q <= 2'b00;
      end else begin
         if (|gnt) begin
            id_q <= gnt[1];
            we_q <= gnt[1] ? m1_we : m0_we;
            size_q <= gnt[1] ? m1_size : m0_size;
            addr_q <= gnt[1] ? m1_addr : m0_addr;
            wdata_q <= gnt[1] ? m1_wdata : m0_wdata;
         end
         if (state == ACCESS) begin
            old_q <= mem_rd;
            rdata_q <= we_q ? '0 : mem_rd & mask;
         end
         rv_q <= nxt == RESP ? (id_q ? 2'b10 : 2'b01) : 2'b00;
      end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random accesses checked against a byte-array memory model
module tb_mem_port_arbiter;
   logic clk, rst_n, fill;
   logic [1:0] req, we;
   logic [1:0] size [2];
   logic [31:0] addr [2];
   logic [31:0] wdata [2];
   logic m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_we;
   logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wd, mem_rd;
   wire [1:0] gnt = {m1_gnt, m0_gnt};
   wire [1:0] rvalid = {m1_rvalid, m0_rvalid};
   logic [7:0] mem [256];
   logic [7:0] ref_mem [256];
   logic [7:0] a8;
   int total = 0;
   int passed = 0;

   mem_port_arbiter #(.ADDR_WIDTH(32), .BYTE_SIZE(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_req(req[0]), .m0_we(we[0]), .m0_size(size[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(req[1]), .m1_we(we[1]), .m1_size(size[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign a8 = mem_addr[7:0];
   assign mem_rd = {mem[8'(a8 + 3)], mem[8'(a8 + 2)], mem[8'(a8 + 1)], mem[a8]};
   always @(posedge clk)
      if (fill) for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 37 + 5);
      else if (mem_we) for (int i = 0; i < 4; i++) mem[8'(a8 + i)] <= mem_wd[8*i +: 8];

   function automatic int nb(input logic [1:0] s);
      return s == 2'd0 ? 1 : s == 2'd1 ? 2 : 4;
   endfunction
   function automatic void ref_store(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
      for (int i = 0; i < nb(s); i++) ref_mem[8'(a + i)] = d[8*i +: 8];
   endfunction
   function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] s);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < nb(s); i++) r[8*i +: 8] = ref_mem[8'(a + i)];
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic xact(input int p, input logic w, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
      int lat;
      logic [31:0] exp;
      lat = (w && s < 2) ? 3 : 2;
      exp = w ? 32'h0 : ref_load(a, s);
      if (w) ref_store(a, s, d);
      we[p] = w; size[p] = s; addr[p] = a; wdata[p] = d; req[p] = 1'b1;
      #1;
      for (int i = 0; i < 20 && !gnt[p]; i++) begin @(negedge clk); #1; end
      chk("gnt_wait", 32'(gnt[p]), 1);
      chk("gnt_other", 32'(gnt[1-p]), 0);
      for (int c = 1; c <= lat; c++) begin
         @(negedge clk); #1;
         if (c == 1) begin req[p] = 1'b0; addr[p] = $urandom; wdata[p] = $urandom; we[p] = ~w; end
         chk("rvalid_latency", 32'(rvalid[p]), 32'(c == lat));
         chk("rvalid_other", 32'(rvalid[1-p]), 0);
      end
      chk("rdata", p ? m1_rdata : m0_rdata, exp);
   endtask

   initial begin
      int ng, nrv, n0, exp_own, eo;
      logic [31:0] exp_w0, exp_w1;
      int own_q [$];
      req = 2'b00; we = 2'b00; rst_n = 1'b0; fill = 1'b1;
      for (int p = 0; p < 2; p++) begin size[p] = 2'd0; addr[p] = '0; wdata[p] = '0; end
      for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 37 + 5);
      repeat (2) @(negedge clk);
      req = 2'b11; #1;
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_rvalid", 32'(rvalid), 0);
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wd", mem_wd, 0);
      chk("rst_rdata0", m0_rdata, 0);
      chk("rst_rdata1", m1_rdata, 0);
      req = 2'b00; rst_n = 1'b1; fill = 1'b0;
      @(negedge clk); #1;

      xact(0, 1'b1, 2'd2, 40, 32'h04030201);
      xact(0, 1'b0, 2'd0, 42, 32'h0);
      chk("tp_byte_load", m0_rdata, 32'h3);

      xact(0, 1'b1, 2'd2, 40, 32'h44332211);
      xact(1, 1'b1, 2'd0, 41, 32'h000000AB);
      xact(0, 1'b0, 2'd2, 40, 32'h0);
      chk("tp_rmw_word", m0_rdata, 32'h4433AB11);

      xact(1, 1'b1, 2'd1, 43, 32'h0000BEEF);
      chk("tp_half_b43", 32'(mem[43]), 32'hEF);
      chk("tp_half_b44", 32'(mem[44]), 32'hBE);
      xact(0, 1'b0, 2'd1, 43, 32'h0);
      chk("tp_half_load", m0_rdata, 32'h0000BEEF);

      // reset arrives while the byte store sits in MERGE: nothing may be written
      we[0] = 1'b1; size[0] = 2'd0; addr[0] = 40; wdata[0] = 32'h77; req[0] = 1'b1; #1;
      for (int i = 0; i < 20 && !m0_gnt; i++) begin @(negedge clk); #1; end
      chk("rm_gnt", 32'(m0_gnt), 1);
      @(negedge clk); #1;
      req[0] = 1'b0;
      chk("rm_access_we", 32'(mem_we), 0);
      @(negedge clk); rst_n = 1'b0; #1;
      chk("rm_merge_we", 32'(mem_we), 0);
      chk("rm_merge_rv", 32'(rvalid), 0);
      @(negedge clk); #1;
      chk("rm_rv", 32'(rvalid), 0);
      chk("rm_idle_addr", mem_addr, 0);
      chk("rm_mem40", 32'(mem[40]), 32'(ref_mem[40]));
      rst_n = 1'b1;

      we = 2'b00; size[0] = 2'd2; size[1] = 2'd2; addr[0] = 40; addr[1] = 44;
      exp_w0 = ref_load(40, 2'd2); exp_w1 = ref_load(44, 2'd2);
      ng = 0; nrv = 0; exp_own = 0;
      req = 2'b11; #1;
      for (int c = 0; c < 60 && nrv < 6; c++) begin
         if (|gnt) begin
            chk("rr_gnt", 32'(gnt), exp_own ? 2 : 1);
            own_q.push_back(gnt[1] ? 1 : 0);
            exp_own ^= 1; ng++;
         end
         if (|rvalid) begin
            eo = own_q.size() > 0 ? own_q.pop_front() : -1;
            chk("rr_rvalid_owner", 32'(rvalid), eo == 1 ? 2 : eo == 0 ? 1 : 3);
            chk("rr_rdata", rvalid[1] ? m1_rdata : m0_rdata, rvalid[1] ? exp_w1 : exp_w0);
            nrv++;
         end
         @(negedge clk); #1;
         if (ng == 6) req = 2'b00;
      end
      req = 2'b00;
      chk("rr_count", nrv, 6);

      ref_store(100, 2'd0, 32'h5A);
      we[0] = 1'b1; size[0] = 2'd0; addr[0] = 100; wdata[0] = 32'h5A; req[0] = 1'b1; #1;
      for (int i = 0; i < 20 && !m0_gnt; i++) begin @(negedge clk); #1; end
      chk("wd_gnt0", 32'(m0_gnt), 1);
      @(negedge clk); #1;
      req[0] = 1'b0; we[1] = 1'b0; size[1] = 2'd2; addr[1] = 0; req[1] = 1'b1; #1;
      chk("wd_gnt1_busy", 32'(m1_gnt), 0);
      @(negedge clk); #1;
      req[1] = 1'b0;
      n0 = 0;
      for (int c = 0; c < 6; c++) begin
         chk("wd_gnt1", 32'(m1_gnt), 0);
         chk("wd_rv1", 32'(m1_rvalid), 0);
         n0 += int'(m0_rvalid);
         @(negedge clk); #1;
      end
      chk("wd_m0_rv", n0, 1);

      for (int k = 0; k < 40; k++)
         xact(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              32'($urandom_range(0, 255)), $urandom);

      for (int i = 0; i < 256; i++) chk("mem_final", 32'(mem[i]), 32'(ref_mem[i]));
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
